// File: rtl/relay_pkg.sv
// Shared constants for the HF relay path: mode selects, front-end mod_type codes,
// start nibbles, end-of-frame patterns and the frame sequencer state encoding.
package relay_pkg;

    localparam logic [2:0] MODE_FAKE_READER = 3'b101;
    localparam logic [2:0] MODE_FAKE_TAG    = 3'b110;

    localparam logic [2:0] MT_SNIFFER       = 3'b000;
    localparam logic [2:0] MT_TAGSIM_LISTEN = 3'b001;
    localparam logic [2:0] MT_TAGSIM_MOD    = 3'b010;
    localparam logic [2:0] MT_READER_LISTEN = 3'b011;
    localparam logic [2:0] MT_READER_MOD    = 3'b100;

    localparam logic [3:0] START_READER = 4'hC;
    localparam logic [3:0] START_TAG    = 4'hF;

    localparam logic [15:0] END_READER_A = 16'h0000;
    localparam logic [15:0] END_READER_B = 16'hC000;
    localparam logic [7:0]  END_TAG      = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LISTEN = 3'd1,
        ST_ARMED  = 3'd2,
        ST_MOD    = 3'd3,
        ST_TAIL   = 3'd4
    } relay_state_e;

    // End patterns only count on even nibble positions, so a stray 00 mid-byte is data.
    function automatic logic is_frame_end(input logic reader, input logic [15:0] hist,
                                          input logic [7:0] cnt);
        logic match;
        if (reader) begin
            match = (hist == END_READER_A) || (hist == END_READER_B);
        end else begin
            match = (hist[7:0] == END_TAG);
        end
        return match && (cnt[0] == 1'b0);
    endfunction

endpackage

// File: rtl/relay_frame_timer.sv
// Loadable down-counter shared between the inactivity timeout and the post-frame holdoff.
// Expires on the cycle it reads 1 and parks at 0 instead of wrapping.
module relay_frame_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down until zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/relay_frame_ctrl.sv
// Frame-level sequencer for the HF relay path: drives front-end mod_type from the
// decoded nibble stream, with inactivity timeout, post-frame holdoff and frame length.
module relay_frame_ctrl
    import relay_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int HOLDOFF = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hi_simulate_mod_type,
    input  logic [3:0] nib,
    input  logic       nib_valid,
    input  logic       line_active,
    output logic [2:0] mod_type,
    output logic       frame_active,
    output logic       frame_done,
    output logic [7:0] frame_len,
    output logic       timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    relay_state_e state_q, state_d;
    logic         reader_q, reader_d;
    logic [15:0]  hist_q, hist_d;
    logic [7:0]   count_q, count_d;
    logic [2:0]   mod_type_q, mod_type_d;
    logic         frame_active_q, frame_active_d;
    logic         frame_done_q, frame_done_d;
    logic [7:0]   frame_len_q, frame_len_d;
    logic         timeout_err_q, timeout_err_d;

    logic          mode_ok_s;
    logic          mode_reader_s;
    logic [2:0]    listen_code_s;
    logic [2:0]    mod_code_s;
    logic [3:0]    start_s;
    logic [15:0]   hist_shift_s;
    logic [7:0]    count_inc_s;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_expire_s;

    relay_frame_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expire   (tmr_expire_s)
    );

    // Mode decode and per-mode codes; the latched flavour is used once out of IDLE.
    always_comb begin
        mode_ok_s     = (hi_simulate_mod_type == MODE_FAKE_READER) ||
                        (hi_simulate_mod_type == MODE_FAKE_TAG);
        mode_reader_s = (hi_simulate_mod_type == MODE_FAKE_READER);
        listen_code_s = reader_q ? MT_READER_LISTEN : MT_TAGSIM_LISTEN;
        mod_code_s    = reader_q ? MT_READER_MOD    : MT_TAGSIM_MOD;
        start_s       = reader_q ? START_READER     : START_TAG;
        hist_shift_s  = {hist_q[11:0], nib};
        count_inc_s   = (count_q == 8'd255) ? count_q : count_q + 8'd1;
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d        = state_q;
        reader_d       = reader_q;
        hist_d         = hist_q;
        count_d        = count_q;
        mod_type_d     = mod_type_q;
        frame_active_d = frame_active_q;
        frame_done_d   = 1'b0;
        frame_len_d    = frame_len_q;
        timeout_err_d  = timeout_err_q;
        tmr_load_s     = 1'b0;
        tmr_val_s      = TW'(TIMEOUT);

        // A reader/tag swap drops through IDLE so the new flavour is latched cleanly.
        if (!mode_ok_s || ((state_q != ST_IDLE) && (mode_reader_s != reader_q))) begin
            state_d        = ST_IDLE;
            mod_type_d     = MT_SNIFFER;
            frame_active_d = 1'b0;
            timeout_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_LISTEN;
                    reader_d   = mode_reader_s;
                    mod_type_d = mode_reader_s ? MT_READER_LISTEN : MT_TAGSIM_LISTEN;
                end
                ST_LISTEN, ST_ARMED: begin
                    if (nib_valid && (nib == start_s)) begin
                        state_d        = ST_MOD;
                        mod_type_d     = mod_code_s;
                        frame_active_d = 1'b1;
                        count_d        = 8'd1;
                        hist_d         = {12'h000, start_s};
                        tmr_load_s     = 1'b1;
                    end else if (state_q == ST_ARMED) begin
                        if (nib_valid) begin
                            tmr_load_s = 1'b1;
                        end else if (tmr_expire_s) begin
                            state_d    = ST_LISTEN;
                            mod_type_d = listen_code_s;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else if (line_active) begin
                        state_d    = ST_ARMED;
                        mod_type_d = reader_q ? MT_SNIFFER : MT_TAGSIM_LISTEN;
                        tmr_load_s = 1'b1;
                    end else begin
                        state_d = ST_LISTEN;
                    end
                end
                ST_MOD: begin
                    if (nib_valid) begin
                        hist_d  = hist_shift_s;
                        count_d = count_inc_s;
                        if (is_frame_end(reader_q, hist_shift_s, count_inc_s)) begin
                            state_d        = ST_TAIL;
                            frame_done_d   = 1'b1;
                            frame_len_d    = count_inc_s;
                            mod_type_d     = listen_code_s;
                            frame_active_d = 1'b0;
                            tmr_load_s     = 1'b1;
                            tmr_val_s      = TW'(HOLDOFF);
                        end else begin
                            tmr_load_s = 1'b1;
                        end
                    end else if (tmr_expire_s) begin
                        state_d        = ST_LISTEN;
                        mod_type_d     = listen_code_s;
                        frame_active_d = 1'b0;
                        timeout_err_d  = 1'b1;
                    end else begin
                        state_d = ST_MOD;
                    end
                end
                ST_TAIL: begin
                    if (tmr_expire_s) begin
                        state_d = ST_LISTEN;
                    end else begin
                        state_d = ST_TAIL;
                    end
                end
                default: begin
                    state_d        = ST_IDLE;
                    mod_type_d     = MT_SNIFFER;
                    frame_active_d = 1'b0;
                end
            endcase
        end
    end

    // State, history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            reader_q       <= 1'b0;
            hist_q         <= 16'h0000;
            count_q        <= 8'd0;
            mod_type_q     <= MT_SNIFFER;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_len_q    <= 8'd0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            reader_q       <= reader_d;
            hist_q         <= hist_d;
            count_q        <= count_d;
            mod_type_q     <= mod_type_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
            frame_len_q    <= frame_len_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign mod_type     = mod_type_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;
    assign frame_len    = frame_len_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_relay_frame_ctrl.sv
// Directed bench for relay_frame_ctrl: reader and tag framing, timeouts,
// mode switching, length saturation and asynchronous reset.
module tb_relay_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] hi_simulate_mod_type;
    logic [3:0] nib;
    logic       nib_valid;
    logic       line_active;
    logic [2:0] mod_type;
    logic       frame_active;
    logic       frame_done;
    logic [7:0] frame_len;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;

    relay_frame_ctrl #(.TIMEOUT(4096), .HOLDOFF(64)) dut (
        .clk                  (clk),
        .reset                (reset),
        .hi_simulate_mod_type (hi_simulate_mod_type),
        .nib                  (nib),
        .nib_valid            (nib_valid),
        .line_active          (line_active),
        .mod_type             (mod_type),
        .frame_active         (frame_active),
        .frame_done           (frame_done),
        .frame_len            (frame_len),
        .timeout_err          (timeout_err)
    );

    always #5 clk = ~clk;

    // Tally frame_done pulses mid-cycle so silent periods can be checked for stray ends.
    always @(negedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_nib(input logic [3:0] v);
        nib       = v;
        nib_valid = 1'b1;
        tick(1);
        nib_valid = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        hi_simulate_mod_type = 3'b000;
        nib                  = 4'h0;
        nib_valid            = 1'b0;
        line_active          = 1'b0;
        tick(2);
        check_eq("rst_mod_type", 32'(mod_type), 32'd0);
        check_eq("rst_frame_len", 32'(frame_len), 32'd0);
        check_eq("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick(1);
        check_eq("idle_mod_type", 32'(mod_type), 32'd0);

        // Reader frame C,0,1,2,0,0,0,0
        hi_simulate_mod_type = 3'b101;
        tick(1);
        check_eq("rd_listen", 32'(mod_type), 32'h3);
        line_active = 1'b1;
        tick(1);
        line_active = 1'b0;
        check_eq("rd_armed", 32'(mod_type), 32'h0);
        send_nib(4'hC);
        check_eq("rd_mod", 32'(mod_type), 32'h4);
        check_eq("rd_active", 32'(frame_active), 32'd1);
        send_nib(4'h0); send_nib(4'h1); send_nib(4'h2);
        send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
        check_eq("rd_still_mod", 32'(mod_type), 32'h4);
        send_nib(4'h0);
        check_eq("rd_done", 32'(frame_done), 32'd1);
        check_eq("rd_len", 32'(frame_len), 32'd8);
        check_eq("rd_back_listen", 32'(mod_type), 32'h3);
        check_eq("rd_inactive", 32'(frame_active), 32'd0);
        tick(1);
        check_eq("rd_done_pulse", 32'(frame_done), 32'd0);
        send_nib(4'hC);
        check_eq("tail_ignores", 32'(mod_type), 32'h3);
        tick(70);

        // Reader -> tag passes through IDLE
        hi_simulate_mod_type = 3'b110;
        tick(1);
        check_eq("sw_idle", 32'(mod_type), 32'h0);
        tick(1);
        check_eq("tag_listen", 32'(mod_type), 32'h1);

        // Tag frame F,5,0,0
        send_nib(4'hF);
        check_eq("tag_mod", 32'(mod_type), 32'h2);
        send_nib(4'h5); send_nib(4'h0);
        check_eq("tag_odd_no_end", 32'(mod_type), 32'h2);
        send_nib(4'h0);
        check_eq("tag_done", 32'(frame_done), 32'd1);
        check_eq("tag_len", 32'(frame_len), 32'd4);
        check_eq("tag_listen2", 32'(mod_type), 32'h1);
        tick(70);

        // F,0,0: 00 at odd count is data; the next 0 closes at count 4
        d0 = done_cnt;
        send_nib(4'hF); send_nib(4'h0); send_nib(4'h0);
        check_eq("tag_odd00_mod", 32'(mod_type), 32'h2);
        check_eq("tag_odd00_nodone", 32'(done_cnt), 32'(d0));
        send_nib(4'h0);
        check_eq("tag_even00_len", 32'(frame_len), 32'd4);
        check_eq("tag_even00_done", 32'(frame_done), 32'd1);
        tick(70);

        // Frame timeout after 4096 idle clocks
        send_nib(4'hF);
        d0 = done_cnt;
        tick(4095);
        check_eq("to_before", 32'(mod_type), 32'h2);
        tick(1);
        check_eq("to_listen", 32'(mod_type), 32'h1);
        check_eq("to_err", 32'(timeout_err), 32'd1);
        check_eq("to_inactive", 32'(frame_active), 32'd0);
        check_eq("to_len_kept", 32'(frame_len), 32'd4);
        check_eq("to_no_done", 32'(done_cnt), 32'(d0));
        hi_simulate_mod_type = 3'b000;
        tick(1);
        check_eq("off_mod_type", 32'(mod_type), 32'h0);
        check_eq("off_clears_err", 32'(timeout_err), 32'd0);

        // ARMED with non-start nibbles, then silence
        hi_simulate_mod_type = 3'b101;
        tick(1);
        line_active = 1'b1;
        tick(1);
        line_active = 1'b0;
        send_nib(4'h3); send_nib(4'h7);
        tick(4095);
        check_eq("arm_hold", 32'(mod_type), 32'h0);
        tick(1);
        check_eq("arm_expire", 32'(mod_type), 32'h3);
        check_eq("arm_no_err", 32'(timeout_err), 32'd0);

        // Mode change mid-frame
        send_nib(4'hC);
        check_eq("mc_mod", 32'(mod_type), 32'h4);
        d0 = done_cnt;
        hi_simulate_mod_type = 3'b110;
        tick(1);
        check_eq("mc_idle", 32'(mod_type), 32'h0);
        check_eq("mc_inactive", 32'(frame_active), 32'd0);
        tick(1);
        check_eq("mc_tag_listen", 32'(mod_type), 32'h1);
        check_eq("mc_no_done", 32'(done_cnt), 32'(d0));

        // Long tag frame closing at count 254
        send_nib(4'hF);
        for (int i = 0; i < 251; i++) send_nib(4'h5);
        send_nib(4'h0); send_nib(4'h0);
        check_eq("long_len", 32'(frame_len), 32'd254);
        check_eq("long_listen", 32'(mod_type), 32'h1);
        tick(70);

        // 300 nibbles saturate at 255, which is odd, so a trailing 00 cannot close the frame
        d0 = done_cnt;
        send_nib(4'hF);
        for (int i = 0; i < 299; i++) send_nib(4'h5);
        send_nib(4'h0); send_nib(4'h0);
        check_eq("sat_still_mod", 32'(mod_type), 32'h2);
        check_eq("sat_no_done", 32'(done_cnt), 32'(d0));

        // Asynchronous reset mid-MOD, no clock edge in between
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_mod_type", 32'(mod_type), 32'h0);
        check_eq("ar_active", 32'(frame_active), 32'd0);
        check_eq("ar_len", 32'(frame_len), 32'd0);
        check_eq("ar_done", 32'(frame_done), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        check_eq("post_rst_listen", 32'(mod_type), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
